// File: rtl/rbi_pkg.sv
// Shared types and helpers for the RBI register bank.
package rbi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rbi_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_RO,
    ERR_PROTO
  } rbi_err_e;

  // Number of byte-address bits spanned by one register.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/rbi_addr_decode.sv
// Combinational address decode: register index, RW/RO hit and range/alignment error.
module rbi_addr_decode
  import rbi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RW     = 8,
  parameter int                    NUM_RO     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  hit_rw,
  output logic                  hit_ro,
  output rbi_err_e              err
);

  localparam int                    SH         = byte_shift(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = (ADDR_WIDTH'(1) << SH) - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] RW_COUNT   = ADDR_WIDTH'(NUM_RW);
  localparam logic [ADDR_WIDTH-1:0] REG_COUNT  = ADDR_WIDTH'(NUM_RW + NUM_RO);

  logic [ADDR_WIDTH-1:0] off;
  logic                  below;
  logic                  beyond;
  logic                  misaligned;

  always_comb begin
    off        = addr - BASE_ADDR;
    idx        = off >> SH;
    below      = addr < BASE_ADDR;
    beyond     = idx >= REG_COUNT;
    misaligned = |(off & ALIGN_MASK);
    if (below || beyond) begin
      err = ERR_RANGE;
    end else if (misaligned) begin
      err = ERR_ALIGN;
    end else begin
      err = ERR_NONE;
    end
    hit_rw = (err == ERR_NONE) && (idx < RW_COUNT);
    hit_ro = (err == ERR_NONE) && !(idx < RW_COUNT);
  end

endmodule

// File: rtl/rbi_reg_bank.sv
// RBI subordinate register bank: NUM_RW read/write registers followed by NUM_RO
// read-only status registers, with a registered one-cycle ack after optional wait states.
module rbi_reg_bank
  import rbi_pkg::*;
#(
  parameter int                           ADDR_WIDTH  = 32,
  parameter int                           DATA_WIDTH  = 32,
  parameter int                           NUM_RW      = 8,
  parameter int                           NUM_RO      = 4,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR   = '0,
  parameter int                           WAIT_STATES = 0,
  parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET    = '0,
  localparam int                          RO_SLOTS    = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           write_en,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH-1:0]          wbit_mask,
  output logic                           write_ack,
  output logic                           write_err,
  input  logic                           read_en,
  output logic                           read_ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           read_err,
  output logic                           ready,
  output logic [NUM_RW*DATA_WIDTH-1:0]   hw_rw_q,
  output logic [NUM_RW-1:0]              hw_wr_pulse,
  input  logic [RO_SLOTS*DATA_WIDTH-1:0] hw_ro_d
);

  rbi_state_e state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] mask_reg;
  logic                  rd_reg;
  logic                  wr_reg;

  logic                  write_ack_reg, write_err_reg;
  logic                  read_ack_reg, read_err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [NUM_RW-1:0]     pulse_reg;

  logic                  in_idle;
  logic                  accept;
  logic                  enter_resp;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_mask;
  logic                  req_rd;
  logic                  req_wr;

  logic [ADDR_WIDTH-1:0] dec_idx;
  logic                  dec_hit_rw;
  logic                  dec_hit_ro;
  rbi_err_e              dec_err;
  rbi_err_e              err_code;
  logic                  req_err;
  logic                  wr_commit;
  logic [NUM_RW-1:0]     wr_sel;
  logic [DATA_WIDTH-1:0] rd_val;

  assign in_idle = (state_reg == IDLE);
  assign accept  = in_idle && (read_en || write_en);
  assign ready   = in_idle;

  // With no wait states the commit edge is the accept edge, so the live request is used.
  assign req_addr  = in_idle ? addr      : addr_reg;
  assign req_wdata = in_idle ? wdata     : wdata_reg;
  assign req_mask  = in_idle ? wbit_mask : mask_reg;
  assign req_rd    = in_idle ? read_en   : rd_reg;
  assign req_wr    = in_idle ? write_en  : wr_reg;

  rbi_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_RW    (NUM_RW),
    .NUM_RO    (NUM_RO),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr  (req_addr),
    .idx   (dec_idx),
    .hit_rw(dec_hit_rw),
    .hit_ro(dec_hit_ro),
    .err   (dec_err)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (read_en || write_en) begin
          if (WAIT_STATES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP) && (state_reg != RESP);

  // ERR_RO can only arise for a pure write, so one error flag serves both directions.
  always_comb begin
    if (req_rd && req_wr) begin
      err_code = ERR_PROTO;
    end else if (dec_err != ERR_NONE) begin
      err_code = dec_err;
    end else if (req_wr && !dec_hit_rw) begin
      err_code = ERR_RO;
    end else begin
      err_code = ERR_NONE;
    end
  end

  assign req_err   = (err_code != ERR_NONE);
  assign wr_commit = enter_resp && req_wr && !req_err;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (dec_hit_rw && (dec_idx == ADDR_WIDTH'(i))) begin
        rd_val = hw_rw_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (dec_hit_ro && (dec_idx == ADDR_WIDTH'(NUM_RW + j))) begin
        rd_val = hw_ro_d[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
      logic [DATA_WIDTH-1:0] q_reg;

      assign wr_sel[gi] = wr_commit && (dec_idx == ADDR_WIDTH'(gi));
      assign hw_rw_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= RW_RESET[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_sel[gi]) begin
          q_reg <= (q_reg & ~req_mask) | (req_wdata & req_mask);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mask_reg      <= '0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      write_ack_reg <= 1'b0;
      write_err_reg <= 1'b0;
      read_ack_reg  <= 1'b0;
      read_err_reg  <= 1'b0;
      rdata_reg     <= '0;
      pulse_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        addr_reg  <= addr;
        wdata_reg <= wdata;
        mask_reg  <= wbit_mask;
        rd_reg    <= read_en;
        wr_reg    <= write_en;
      end
      read_ack_reg  <= enter_resp && req_rd;
      read_err_reg  <= enter_resp && req_rd && req_err;
      write_ack_reg <= enter_resp && req_wr;
      write_err_reg <= enter_resp && req_wr && req_err;
      pulse_reg     <= wr_sel;
      if (enter_resp && req_rd) begin
        rdata_reg <= req_err ? '0 : rd_val;
      end
    end
  end

  assign write_ack   = write_ack_reg;
  assign write_err   = write_err_reg;
  assign read_ack    = read_ack_reg;
  assign read_err    = read_err_reg;
  assign rdata       = rdata_reg;
  assign hw_wr_pulse = pulse_reg;

endmodule

// File: tb/tb_rbi_reg_bank.sv
// Directed bench for rbi_reg_bank: a zero-wait-state bank and a three-wait-state bank.
module tb_rbi_reg_bank;

  localparam logic [255:0] RST_VEC = {32'h7000_0007, 32'h6000_0006, 32'h5000_0005,
                                      32'h4000_0004, 32'h3000_0003, 32'hA5A5_0002,
                                      32'hFFFF_0000, 32'h1111_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  addr = '0, wdata = '0, wbit_mask = '0;
  logic         write_en = 1'b0, read_en = 1'b0;
  logic         write_ack, write_err, read_ack, read_err, ready;
  logic [31:0]  rdata;
  logic [255:0] hw_rw_q;
  logic [7:0]   hw_wr_pulse;
  logic [127:0] hw_ro_d = '0;

  logic [31:0]  ws_addr = '0, ws_wdata = '0, ws_wbit_mask = '0;
  logic         ws_write_en = 1'b0, ws_read_en = 1'b0;
  logic         ws_write_ack, ws_write_err, ws_read_ack, ws_read_err, ws_ready;
  logic [31:0]  ws_rdata;
  logic [255:0] ws_hw_rw_q;
  logic [7:0]   ws_hw_wr_pulse;
  logic [127:0] ws_hw_ro_d = '0;

  rbi_reg_bank #(.WAIT_STATES(0), .RW_RESET(RST_VEC)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_en(write_en), .wdata(wdata),
    .wbit_mask(wbit_mask), .write_ack(write_ack), .write_err(write_err),
    .read_en(read_en), .read_ack(read_ack), .rdata(rdata), .read_err(read_err),
    .ready(ready), .hw_rw_q(hw_rw_q), .hw_wr_pulse(hw_wr_pulse), .hw_ro_d(hw_ro_d)
  );

  rbi_reg_bank #(.WAIT_STATES(3), .RW_RESET(RST_VEC)) dut_ws (
    .clk(clk), .rst(rst), .addr(ws_addr), .write_en(ws_write_en), .wdata(ws_wdata),
    .wbit_mask(ws_wbit_mask), .write_ack(ws_write_ack), .write_err(ws_write_err),
    .read_en(ws_read_en), .read_ack(ws_read_ack), .rdata(ws_rdata), .read_err(ws_read_err),
    .ready(ws_ready), .hw_rw_q(ws_hw_rw_q), .hw_wr_pulse(ws_hw_wr_pulse), .hw_ro_d(ws_hw_ro_d)
  );

  int tests = 0;
  int fails = 0;

  logic         got_ack, got_rack, got_rerr, got_wack, got_werr, got_after;
  logic [31:0]  got_rdata;
  logic [7:0]   got_pulse;
  int           got_lat;
  logic [255:0] exp_rw;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the zero-wait bank, hold it through the ack cycle, then release.
  task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] m);
    int n;
    read_en = rd; write_en = wr; addr = a; wdata = d; wbit_mask = m;
    n = 0;
    got_ack = 1'b0;
    while (n < 20 && !got_ack) begin
      @(posedge clk); #1;
      n++;
      got_ack = read_ack | write_ack;
    end
    got_lat = n;   got_rack = read_ack; got_rerr = read_err;
    got_wack = write_ack; got_werr = write_err;
    got_rdata = rdata; got_pulse = hw_wr_pulse;
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0;
    got_after = read_ack | write_ack | (|hw_wr_pulse);
    $display("[TB] rd=%0b wr=%0b addr=%08h wdata=%08h mask=%08h lat=%0d rack=%0b rerr=%0b wack=%0b werr=%0b rdata=%08h pulse=%02h",
             rd, wr, a, d, m, got_lat, got_rack, got_rerr, got_wack, got_werr, got_rdata, got_pulse);
    check("ack_seen", 256'(got_ack), 256'(1));
    check("ack_one_cycle", 256'(got_after), 256'(0));
  endtask

  initial begin
    int  n;
    logic seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    exp_rw = RST_VEC;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset defaults
    check("rst_ready", 256'(ready), 256'(1));
    check("rst_acks", 256'({read_ack, write_ack, read_err, write_err}), 256'(0));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_pulse", 256'(hw_wr_pulse), 256'(0));
    check("rst_rw_q", hw_rw_q, RST_VEC);
    check("rst_ws_ready", 256'(ws_ready), 256'(1));

    run(1'b1, 1'b0, 32'h00, 32'h0, 32'h0);
    check("rd0_lat", 256'(got_lat), 256'(1));
    check("rd0_data", 256'(got_rdata), 256'(32'h1111_0000));
    check("rd0_err", 256'({got_rerr, got_wack}), 256'(0));

    // Masked write to reg1
    run(1'b0, 1'b1, 32'h04, 32'h1234_5678, 32'h0000_FFFF);
    exp_rw[63:32] = 32'hFFFF_5678;
    check("wr1_ack", 256'({got_wack, got_werr, got_rack}), 256'(3'b100));
    check("wr1_pulse", 256'(got_pulse), 256'(8'h02));
    check("wr1_q", hw_rw_q, exp_rw);
    run(1'b1, 1'b0, 32'h04, 32'h0, 32'h0);
    check("rd1_data", 256'(got_rdata), 256'(32'hFFFF_5678));

    // Full-mask write to reg0 and readback
    run(1'b0, 1'b1, 32'h00, 32'h0BAD_F00D, 32'hFFFF_FFFF);
    exp_rw[31:0] = 32'h0BAD_F00D;
    check("wr0_pulse", 256'(got_pulse), 256'(8'h01));
    run(1'b1, 1'b0, 32'h00, 32'h0, 32'h0);
    check("rd0b_data", 256'(got_rdata), 256'(32'h0BAD_F00D));

    // RO path, last RW and last RO
    hw_ro_d[31:0]   = 32'hCAFE_F00D;
    hw_ro_d[127:96] = 32'h0BAD_BEEF;
    run(1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
    check("ro0_data", 256'(got_rdata), 256'(32'hCAFE_F00D));
    check("ro0_err", 256'(got_rerr), 256'(0));
    run(1'b1, 1'b0, 32'h2C, 32'h0, 32'h0);
    check("ro3_data", 256'(got_rdata), 256'(32'h0BAD_BEEF));
    run(1'b1, 1'b0, 32'h1C, 32'h0, 32'h0);
    check("rw7_data", 256'(got_rdata), 256'(32'h7000_0007));
    run(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hFFFF_FFFF);
    check("ro_wr_err", 256'({got_wack, got_werr}), 256'(2'b11));
    check("ro_wr_pulse", 256'(got_pulse), 256'(0));
    check("ro_wr_q", hw_rw_q, exp_rw);

    // Decode errors
    run(1'b1, 1'b0, 32'h30, 32'h0, 32'h0);
    check("oor_rd_err", 256'({got_rack, got_rerr}), 256'(2'b11));
    check("oor_rd_data", 256'(got_rdata), 256'(0));
    run(1'b0, 1'b1, 32'h06, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mis_wr_err", 256'({got_wack, got_werr}), 256'(2'b11));
    check("mis_wr_q", hw_rw_q, exp_rw);
    run(1'b1, 1'b0, 32'h04, 32'h0, 32'h0);
    check("pre_proto_data", 256'(got_rdata), 256'(32'hFFFF_5678));
    run(1'b1, 1'b1, 32'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("proto_flags", 256'({got_rack, got_rerr, got_wack, got_werr}), 256'(4'b1111));
    check("proto_data", 256'(got_rdata), 256'(0));
    check("proto_pulse", 256'(got_pulse), 256'(0));
    check("proto_q", hw_rw_q, exp_rw);

    // Wait states: read of reg3, then a held back-to-back write to reg4
    ws_addr = 32'h0C; ws_read_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("ws_rd_ready", 256'(ws_ready), 256'(0));
      check("ws_rd_ack", 256'(ws_read_ack), 256'(k == 4));
    end
    check("ws_rd_data", 256'(ws_rdata), 256'(32'h3000_0003));
    $display("[TB] ws rd addr=%08h rdata=%08h rerr=%0b", ws_addr, ws_rdata, ws_read_err);
    ws_read_en = 1'b0; ws_write_en = 1'b1; ws_addr = 32'h10;
    ws_wdata = 32'h55AA_55AA; ws_wbit_mask = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("ws_b2b_ready", 256'(ws_ready), 256'(1));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("ws_wr_ready", 256'(ws_ready), 256'(0));
      check("ws_wr_ack", 256'(ws_write_ack), 256'(k == 4));
      check("ws_wr_pulse", 256'(ws_hw_wr_pulse), (k == 4) ? 256'(8'h10) : 256'(0));
    end
    @(posedge clk); #1;
    ws_write_en = 1'b0;
    check("ws_wr_q", 256'(ws_hw_rw_q[159:128]), 256'(32'h55AA_55AA));
    $display("[TB] ws wr addr=%08h wdata=%08h reg4=%08h", ws_addr, ws_wdata, ws_hw_rw_q[159:128]);

    // Complete a write to reg2 on the wait-state bank
    ws_addr = 32'h08; ws_wdata = 32'h1234_ABCD; ws_write_en = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 10 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = ws_write_ack;
    end
    check("ws_wr2_ack", 256'(seen), 256'(1));
    @(posedge clk); #1;
    ws_write_en = 1'b0;
    check("ws_wr2_q", 256'(ws_hw_rw_q[95:64]), 256'(32'h1234_ABCD));
    $display("[TB] ws wr addr=%08h wdata=%08h reg2=%08h", ws_addr, ws_wdata, ws_hw_rw_q[95:64]);

    // Reset while the next write to reg2 sits in WAIT
    ws_wdata = 32'hDEAD_BEEF; ws_write_en = 1'b1;
    @(posedge clk); #1;
    check("mid_ready", 256'(ws_ready), 256'(0));
    rst = 1'b1; ws_write_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ack", 256'(ws_write_ack), 256'(0));
    check("mid_rst_reg2", 256'(ws_hw_rw_q[95:64]), 256'(32'hA5A5_0002));
    check("mid_rst_reg4", 256'(ws_hw_rw_q[159:128]), 256'(32'h4000_0004));
    check("mid_rst_dut0", hw_rw_q, RST_VEC);
    @(posedge clk); #1;
    check("post_rst_ready", 256'(ws_ready), 256'(1));
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ws_write_ack | ws_read_ack;
    end
    check("post_rst_no_ack", 256'(seen), 256'(0));
    $display("[TB] ws reset mid-write reg2=%08h ready=%0b", ws_hw_rw_q[95:64], ws_ready);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rbi_reg_bank.md
Name: rbi_reg_bank

Overview:
RBI subordinate: responds to an RBI manager's read/write requests and implements a bank of NUM_RW read/write registers followed by NUM_RO read-only status registers.
- RW register contents go out to hardware as a flat vector; RO values come in from hardware.
- Sits at the subordinate end of an RBI link, typically one bank per peripheral.

Parameters:
- ADDR_WIDTH, 32: address bus width.
- DATA_WIDTH, 32: data width. Must be 8 x a power of two.
- NUM_RW, 8: number of RW registers. Must be at least 1.
- NUM_RO, 4: number of RO registers. Must be at least 0.
- BASE_ADDR, 0: byte address of register 0. Must be aligned to DATA_WIDTH/8.
- WAIT_STATES, 0: extra cycles inserted between accept and ack. Range 0-15.
- RW_RESET, '0: reset value of the RW registers, a NUM_RW*DATA_WIDTH packed vector; register i uses slice i.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- addr  in  ADDR_WIDTH  byte address.
- write_en  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- wbit_mask  in  DATA_WIDTH  per-bit write enable.
- write_ack  out  1  write completion.
- write_err  out  1  write error, valid with write_ack.
- read_en  in  1  read request.
- read_ack  out  1  read completion.
- rdata  out  DATA_WIDTH  read data, valid with read_ack.
- read_err  out  1  read error, valid with read_ack.
- ready  out  1  high when the bank can accept a request.
- hw_rw_q  out  NUM_RW*DATA_WIDTH  current RW register values.
- hw_wr_pulse  out  NUM_RW  one-cycle pulse per successful write to register i.
- hw_ro_d  in  max(NUM_RO,1)*DATA_WIDTH  RO register sources.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - write_ack, write_err, read_ack, read_err, hw_wr_pulse: 0.
  - rdata: 0.
  - ready: 1.
  - RW registers: RW_RESET.
  - FSM: IDLE.
- Handshake:
  - Manager raises read_en or write_en with addr, wdata and wbit_mask, and holds them stable until it sees the matching ack.
  - A transfer completes in the cycle where en and ack are both high.
  - The manager may keep en high into the next cycle to start a back-to-back request.
- FSM states:
  - IDLE: ready=1. If (read_en|write_en), capture request fields and decode; go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: ready=0. Count down WAIT_STATES cycles, then go to RESP.
  - RESP: ready=0. The ack is registered, so it is high for exactly one cycle, in this state. Next state is IDLE.
- Latency: request sampled in IDLE at cycle N gives ack at cycle N+1+WAIT_STATES. Best-case throughput is one transfer per 2 cycles.
- Decode:
  - off = addr - BASE_ADDR, computed at ADDR_WIDTH with wrap.
  - idx = off >> log2(DATA_WIDTH/8).
  - Address is out of range if addr < BASE_ADDR or idx >= NUM_RW+NUM_RO.
  - Address is misaligned if the low log2(DATA_WIDTH/8) bits of off are non-zero.
- Errors; on any error there is no register update and no hw_wr_pulse:
  - Read: out of range or misaligned gives read_err=1 and rdata=0.
  - Write: out of range, misaligned, or idx >= NUM_RW (RO target) gives write_err=1.
  - Both read_en and write_en high in IDLE: protocol error. Both read_ack/read_err and write_ack/write_err are asserted in RESP, there is no write, and rdata=0.
- Write commit:
  - On the edge entering RESP: reg[idx] <= (reg[idx] & ~wbit_mask) | (wdata & wbit_mask).
  - hw_wr_pulse[idx]=1 during RESP, even if wbit_mask=0.
- Read data:
  - rdata is registered on the edge entering RESP.
  - Source is reg[idx] for RW registers, or hw_ro_d slice idx-NUM_RW for RO registers, sampled at that edge.
  - rdata holds its value until the next read completes.
- A read following a write to the same register returns the new value.
- Reset mid-transfer: FSM goes to IDLE, a pending ack is dropped, registers reload RW_RESET, and the manager must reissue.
- Requests arriving while ready=0 are ignored until IDLE. The manager holds en, so the request is accepted then.

Decomposition:
- Package rbi_pkg:
  - rbi_state_e {IDLE, WAIT, RESP}.
  - rbi_err_e {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_RO, ERR_PROTO}, for debug and assertions.
  - Function byte_shift(DATA_WIDTH).
- Sub-module rbi_addr_decode: combinational. Inputs addr. Outputs idx, hit_rw, hit_ro, err code.
- The FSM, register array and response path stay in rbi_reg_bank.

Test Plan:
1. Reset defaults: after reset, read 0x00 -> read_ack at cycle N+1, rdata=RW_RESET slice 0, read_err=0. hw_rw_q matches RW_RESET.
2. Masked write: reg1=0xFFFF0000; write addr 0x04, wdata 0x12345678, mask 0x0000FFFF -> write_ack, no error, hw_wr_pulse[1] for one cycle, reg1=0xFFFF5678. Readback returns 0xFFFF5678.
3. RO path and RO-write error: hw_ro_d slice 0=0xCAFEF00D; read 0x20 -> 0xCAFEF00D. Write 0x20 -> write_err=1, no pulse, value unchanged.
4. Decode errors: read 0x30 (idx 12) -> read_err=1, rdata=0. Write 0x06 -> write_err=1, reg1 unchanged. read_en and write_en together -> both acks and both errs asserted.
5. Wait states: WAIT_STATES=3; read accepted at cycle 10 -> read_ack at cycle 14, ready=0 during cycles 11-14. Back-to-back held write_en is accepted at cycle 15.
6. Reset mid-operation: assert rst during WAIT after a write to 0x08 -> no ack, reg2=RW_RESET slice 2, ready=1 the cycle after reset drops.
